instr_fetch_stage: RTL and testbench
====================================

# instr_fetch_stage

Consumer side of the instruction-address interface. Accepts the next instruction address as a pstate pair (pstate0 = status + segment, pstate1 = offset) from the instruction address stage. Issues one request per address to the instruction cache and waits for a variable-latency acknowledge. Delivers the fetched instruction word with its pstate pair, or a trap code, to the decode stage under a valid/ready handshake.

## Interface
- WORD_LENGTH, 32 (from defines.vh), data/address word width
- SEG_BITS, 16, segment id width; segment = inPstate0[SEG_BITS-1:0]
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- inPstate0  in  WORD_LENGTH  status + segment of next instruction
- inPstate1  in  WORD_LENGTH  instruction offset
- inValid  in  1  address stage presents a valid pstate pair
- outReady  out  1  fetch stage accepts pair this cycle
- flush  in  1  kill pending/held fetch (branch redirect, trap)
- icReq  out  1  I-cache request
- icSeg  out  SEG_BITS  request segment
- icOfs  out  WORD_LENGTH  request offset
- icAck  in  1  I-cache response valid; completes request
- icData  in  WORD_LENGTH  instruction word, valid with icAck
- icErr  in  1  access error, valid with icAck
- outValid  out  1  instruction/trap available to decode
- inDecReady  in  1  decode consumes this cycle
- outInstr  out  WORD_LENGTH  fetched instruction (0 on trap)
- outPstate0  out  WORD_LENGTH  pstate0 of that instruction
- outPstate1  out  WORD_LENGTH  pstate1 of that instruction
- outTrap  out  2  0 none, 1 misaligned offset, 2 I-cache access error

## Operation
- FSM states: IDLE, FETCH, DISCARD, HOLD.
- IDLE: outReady=1. On inValid & !flush, latch both pstates.
  - If inPstate1[1:0] != 0, go to HOLD with outTrap=1. No icReq is issued.
  - Otherwise go to FETCH.
- FETCH: icReq=1, icSeg/icOfs stable from latched pstate, held until icAck.
  - On icAck & !flush: capture icData, set outTrap = icErr ? 2 : 0 (outInstr=0 if error), go to HOLD.
  - On flush & !icAck: go to DISCARD.
  - On flush & icAck: drop the response, go to IDLE.
- DISCARD: icReq stays 1 (a request is never withdrawn). On icAck, drop the response and go to IDLE. Further flush has no effect.
- HOLD: outValid = !flush.
  - On inDecReady & !flush: transfer. outReady=inDecReady, so a new pair can be accepted in the same cycle (→ FETCH or HOLD-with-trap). Otherwise go to IDLE.
  - On flush: go to IDLE, no transfer; flush wins over inDecReady.
- outReady = !rst & (IDLE | (HOLD & inDecReady & !flush)).
- Reset (any cycle, including mid-FETCH): state=IDLE; icReq, outValid, outTrap, outInstr, outPstate0/1, icSeg, icOfs all 0. The cache side must also be reset; an in-flight ack after reset is ignored in IDLE.
- icAck outside FETCH/DISCARD is ignored.

## Timing
- Accept at edge N. icReq=1 from cycle N+1 (registered).
- icAck in cycle M. outValid=1 from M+1. Minimum accept→outValid latency is 2 cycles with a zero-wait cache.
- Misaligned trap: outValid at N+1, no cache traffic.
- Throughput with a zero-wait cache and always-ready decode: one instruction per 2 cycles.
- outInstr/outPstate*/outTrap are registered and stable while outValid & !inDecReady.
- All outputs except outReady and outValid are direct flop outputs.

## Structure
- Shared package vcpu32_pkg holds:
  - the fetch state enum (IDLE, FETCH, DISCARD, HOLD)
  - trap code constants TRAP_NONE=0, TRAP_IALIGN=1, TRAP_IACCESS=2
  - SEG_BITS
- WORD_LENGTH stays in defines.vh.
- Single module; no sub-module is warranted.

## Test plan
- Reset mid-FETCH: raise rst while icReq=1 → next edge all outputs 0, state IDLE; a later icAck produces no outValid.
- Aligned fetch: pstate0=0x0000_0012, pstate1=0x0000_1000, cache acks after 3 wait cycles with 0xDEAD_BEEF → icSeg=0x0012, icOfs=0x1000; outValid one cycle after ack; outInstr=0xDEAD_BEEF, outTrap=0.
- Misaligned: pstate1=0x0000_1002 → icReq never asserted; outValid at N+1 with outTrap=1, outInstr=0.
- Access error: ack with icErr=1 → outTrap=2, outInstr=0, pstates echoed.
- Flush in FETCH: flush 1 cycle before ack → DISCARD; icReq held until ack, data dropped, no outValid. Variant with flush and ack in the same cycle → IDLE next cycle.
- Back-to-back with decode stalled 2 cycles: outputs stable while stalled; with inDecReady=1 and inValid=1 in HOLD, the new pair is accepted that cycle and icReq rises the next cycle.

Source files
------------

// File: rtl/vcpu32_pkg.sv
// Shared vcpu32 pipeline types: fetch FSM states, trap codes, segment width.
package vcpu32_pkg;

    localparam int SEG_BITS = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } fetch_state_e;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_IALIGN  = 2'd1;
    localparam logic [1:0] TRAP_IACCESS = 2'd2;

endpackage

// File: rtl/instr_fetch_stage.sv
// Instruction fetch: takes a pstate pair, runs one I-cache request,
// hands the word (or a trap) to decode under valid/ready.
module instr_fetch_stage
    import vcpu32_pkg::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_LENGTH-1:0] inPstate0,
    input  logic [WORD_LENGTH-1:0] inPstate1,
    input  logic                   inValid,
    output logic                   outReady,
    input  logic                   flush,
    output logic                   icReq,
    output logic [SEG_BITS-1:0]    icSeg,
    output logic [WORD_LENGTH-1:0] icOfs,
    input  logic                   icAck,
    input  logic [WORD_LENGTH-1:0] icData,
    input  logic                   icErr,
    output logic                   outValid,
    input  logic                   inDecReady,
    output logic [WORD_LENGTH-1:0] outInstr,
    output logic [WORD_LENGTH-1:0] outPstate0,
    output logic [WORD_LENGTH-1:0] outPstate1,
    output logic [1:0]             outTrap
);

    fetch_state_e           state_q, state_d;
    logic [WORD_LENGTH-1:0] p0_q, p0_d;
    logic [WORD_LENGTH-1:0] p1_q, p1_d;
    logic [WORD_LENGTH-1:0] instr_q, instr_d;
    logic [1:0]             trap_q, trap_d;
    logic                   req_q, req_d;
    logic                   accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            p0_q    <= '0;
            p1_q    <= '0;
            instr_q <= '0;
            trap_q  <= TRAP_NONE;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            instr_q <= instr_d;
            trap_q  <= trap_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p0_d    = p0_q;
        p1_d    = p1_q;
        instr_d = instr_q;
        trap_d  = trap_q;
        accept  = 1'b0;

        unique case (state_q)
            IDLE: accept = inValid & ~flush;
            FETCH: begin
                if (icAck && !flush) begin
                    instr_d = icErr ? '0 : icData;
                    trap_d  = icErr ? TRAP_IACCESS : TRAP_NONE;
                    state_d = HOLD;
                end else if (icAck) begin
                    state_d = IDLE;
                end else if (flush) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: if (icAck) state_d = IDLE;
            HOLD: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (inDecReady) begin
                    state_d = IDLE;
                    accept  = inValid;
                end
            end
            default: state_d = IDLE;
        endcase

        // Misaligned offsets never reach the cache; trap is reported directly.
        if (accept) begin
            p0_d    = inPstate0;
            p1_d    = inPstate1;
            instr_d = '0;
            if (inPstate1[1:0] != 2'b00) begin
                trap_d  = TRAP_IALIGN;
                state_d = HOLD;
            end else begin
                trap_d  = TRAP_NONE;
                state_d = FETCH;
            end
        end

        req_d = (state_d == FETCH) || (state_d == DISCARD);
    end

    assign outReady = ~rst & ((state_q == IDLE) |
                      ((state_q == HOLD) & inDecReady & ~flush));
    assign outValid = (state_q == HOLD) & ~flush;

    assign icReq      = req_q;
    assign icSeg      = p0_q[SEG_BITS-1:0];
    assign icOfs      = p1_q;
    assign outInstr   = instr_q;
    assign outPstate0 = p0_q;
    assign outPstate1 = p1_q;
    assign outTrap    = trap_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: vector table plus hand sequences,
// decode-side results checked through an expected-result queue.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inPstate0, inPstate1;
    logic        inValid, outReady, flush;
    logic        icReq;
    logic [15:0] icSeg;
    logic [31:0] icOfs;
    logic        icAck, icErr;
    logic [31:0] icData;
    logic        outValid, inDecReady;
    logic [31:0] outInstr, outPstate0, outPstate1;
    logic [1:0]  outTrap;

    instr_fetch_stage #(.WORD_LENGTH(32)) dut (
        .clk(clk), .rst(rst),
        .inPstate0(inPstate0), .inPstate1(inPstate1),
        .inValid(inValid), .outReady(outReady), .flush(flush),
        .icReq(icReq), .icSeg(icSeg), .icOfs(icOfs),
        .icAck(icAck), .icData(icData), .icErr(icErr),
        .outValid(outValid), .inDecReady(inDecReady),
        .outInstr(outInstr), .outPstate0(outPstate0),
        .outPstate1(outPstate1), .outTrap(outTrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [1:0]  trap;
    } exp_t;

    typedef struct {
        logic [31:0] p0;
        logic [31:0] p1;
        int          wt;
        logic        err;
        logic [31:0] data;
        logic [15:0] seg;
        logic [31:0] ex_instr;
        logic [1:0]  ex_trap;
    } vec_t;

    exp_t sb[$];
    exp_t e_pop;
    vec_t vt[5];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] t);
        exp_t e;
        e.instr = i; e.p0 = a; e.p1 = b; e.trap = t;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && outValid && inDecReady) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got instr %h want none", outInstr);
            end else begin
                e_pop = sb.pop_front();
                chk("out_instr", outInstr, e_pop.instr);
                chk("out_p0", outPstate0, e_pop.p0);
                chk("out_p1", outPstate1, e_pop.p1);
                chk("out_trap", {30'b0, outTrap}, {30'b0, e_pop.trap});
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        inPstate0 = a;
        inPstate1 = b;
        inValid   = 1'b1;
        @(posedge clk); #1;
        inValid   = 1'b0;
    endtask

    initial begin
        vt[0] = '{32'h0000_0012, 32'h0000_1000, 3, 1'b0, 32'hDEAD_BEEF,
                  16'h0012, 32'hDEAD_BEEF, 2'd0};
        vt[1] = '{32'h8000_0034, 32'h0000_1002, 0, 1'b0, 32'h0,
                  16'h0034, 32'h0, 2'd1};
        vt[2] = '{32'h0000_0055, 32'h0000_2004, 0, 1'b1, 32'h1234_5678,
                  16'h0055, 32'h0, 2'd2};
        vt[3] = '{32'h0001_ABCD, 32'hFFFF_FFFC, 1, 1'b0, 32'hCAFE_F00D,
                  16'hABCD, 32'hCAFE_F00D, 2'd0};
        vt[4] = '{32'h0000_0099, 32'h0000_3001, 0, 1'b0, 32'h0,
                  16'h0099, 32'h0, 2'd1};

        rst = 1'b1;
        inPstate0 = '0; inPstate1 = '0; inValid = 1'b0; flush = 1'b0;
        icAck = 1'b0; icErr = 1'b0; icData = '0; inDecReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, outReady}, 32'd0);
        chk("rst_valid", {31'b0, outValid}, 32'd0);
        chk("rst_req", {31'b0, icReq}, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_ready", {31'b0, outReady}, 32'd1);

        for (int k = 0; k < 5; k++) begin
            push(vt[k].ex_instr, vt[k].p0, vt[k].p1, vt[k].ex_trap);
            start(vt[k].p0, vt[k].p1);
            if (vt[k].p1[1:0] != 2'b00) begin
                chk("mis_req", {31'b0, icReq}, 32'd0);
                chk("mis_valid", {31'b0, outValid}, 32'd1);
            end else begin
                chk("req", {31'b0, icReq}, 32'd1);
                chk("seg", {16'b0, icSeg}, {16'b0, vt[k].seg});
                chk("ofs", icOfs, vt[k].p1);
                for (int w = 0; w < vt[k].wt; w++) begin
                    chk("wait_valid", {31'b0, outValid}, 32'd0);
                    @(posedge clk); #1;
                    chk("wait_req", {31'b0, icReq}, 32'd1);
                end
                chk("pre_ack_valid", {31'b0, outValid}, 32'd0);
                icAck = 1'b1; icErr = vt[k].err; icData = vt[k].data;
                @(posedge clk); #1;
                icAck = 1'b0; icErr = 1'b0;
                chk("ack_valid", {31'b0, outValid}, 32'd1);
            end
            @(posedge clk); #1;
        end

        // Reset while a request is outstanding; the late ack must be ignored.
        start(32'h0000_0042, 32'h0000_5000);
        chk("rf_req", {31'b0, icReq}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rf_req0", {31'b0, icReq}, 32'd0);
        chk("rf_p0", outPstate0, 32'd0);
        chk("rf_p1", outPstate1, 32'd0);
        chk("rf_instr", outInstr, 32'd0);
        chk("rf_trap", {30'b0, outTrap}, 32'd0);
        chk("rf_seg", {16'b0, icSeg}, 32'd0);
        rst = 1'b0;
        icAck = 1'b1; icData = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        icAck = 1'b0;
        chk("rf_valid", {31'b0, outValid}, 32'd0);
        chk("rf_ready", {31'b0, outReady}, 32'd1);

        // Flush one cycle before ack -> DISCARD, request held, data dropped.
        start(32'h0000_0001, 32'h0000_6000);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("dc_req", {31'b0, icReq}, 32'd1);
        chk("dc_ready", {31'b0, outReady}, 32'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("dc_req2", {31'b0, icReq}, 32'd1);
        icAck = 1'b1; icData = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        icAck = 1'b0;
        chk("dc_req_off", {31'b0, icReq}, 32'd0);
        chk("dc_valid", {31'b0, outValid}, 32'd0);
        chk("dc_idle", {31'b0, outReady}, 32'd1);

        // Flush and ack in the same cycle -> straight back to IDLE.
        start(32'h0000_0002, 32'h0000_7000);
        flush = 1'b1; icAck = 1'b1; icData = 32'h7777_7777;
        @(posedge clk); #1;
        flush = 1'b0; icAck = 1'b0;
        chk("fa_req", {31'b0, icReq}, 32'd0);
        chk("fa_valid", {31'b0, outValid}, 32'd0);
        chk("fa_idle", {31'b0, outReady}, 32'd1);

        // Back-to-back with a 2-cycle decode stall.
        inDecReady = 1'b0;
        push(32'h1111_2222, 32'h0000_0007, 32'h0000_4000, 2'd0);
        start(32'h0000_0007, 32'h0000_4000);
        icAck = 1'b1; icData = 32'h1111_2222;
        @(posedge clk); #1;
        icAck = 1'b0;
        for (int s = 0; s < 2; s++) begin
            chk("st_valid", {31'b0, outValid}, 32'd1);
            chk("st_instr", outInstr, 32'h1111_2222);
            chk("st_p1", outPstate1, 32'h0000_4000);
            chk("st_ready", {31'b0, outReady}, 32'd0);
            @(posedge clk); #1;
        end
        chk("st_valid_end", {31'b0, outValid}, 32'd1);
        inDecReady = 1'b1;
        push(32'h3333_4444, 32'h0000_0008, 32'h0000_4008, 2'd0);
        inPstate0 = 32'h0000_0008; inPstate1 = 32'h0000_4008; inValid = 1'b1;
        #1;
        chk("bb_ready", {31'b0, outReady}, 32'd1);
        @(posedge clk); #1;
        inValid = 1'b0;
        chk("bb_req", {31'b0, icReq}, 32'd1);
        chk("bb_ofs", icOfs, 32'h0000_4008);
        icAck = 1'b1; icData = 32'h3333_4444;
        @(posedge clk); #1;
        icAck = 1'b0;
        chk("bb_valid", {31'b0, outValid}, 32'd1);
        @(posedge clk); #1;

        // Flush in HOLD wins over a ready decode.
        start(32'h0000_0003, 32'h0000_8003);
        chk("fh_valid_pre", {31'b0, outValid}, 32'd1);
        flush = 1'b1;
        #1;
        chk("fh_valid", {31'b0, outValid}, 32'd0);
        chk("fh_ready", {31'b0, outReady}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fh_after", {31'b0, outValid}, 32'd0);
        chk("fh_idle", {31'b0, outReady}, 32'd1);
        @(posedge clk); #1;

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
